axi_read_xbar: RTL and testbench

AXI_READ_XBAR -- requirements
Module: axi_read_xbar

---
 rtl/axi_xbar_pkg.sv | 26 ++
 rtl/axi_read_xbar_if.sv | 33 +++
 rtl/axi_rr_arbiter.sv | 55 +++++
 rtl/axi_read_xbar.sv | 182 ++++++++++++++++++
 tb/tb_axi_read_xbar.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_xbar_pkg.sv
// Shared types and constants for the AXI read crossbar.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_xbar_pkg;

    // Width of the master index prepended to slave-side IDs
    localparam int MIDX_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } xbar_state_t;

    // AR payload without the ID, whose width is a block parameter
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_pld_t;

endpackage

// File: rtl/axi_read_xbar_if.sv
// Bundle of N AXI read channels (AR + R), one array element per port.
// Latency: n/a (wiring only).
// Backpressure: standard AXI valid/ready on both AR and R.
interface axi_read_xbar_if #(
    parameter int N   = 1,
    parameter int IDW = 4
);
    logic [IDW-1:0] arid    [N];
    logic [31:0]    araddr  [N];
    logic [3:0]     arlen   [N];
    logic [2:0]     arsize  [N];
    logic [1:0]     arburst [N];
    logic           arvalid [N];
    logic           arready [N];
    logic [IDW-1:0] rid     [N];
    logic [31:0]    rdata   [N];
    logic [1:0]     rresp   [N];
    logic           rlast   [N];
    logic           rvalid  [N];
    logic           rready  [N];

    // Issuer of read requests
    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    // Responder to read requests
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rr_arbiter.sv
// Request arbiter: round-robin when AXI_RR_ARB_EN is defined, else fixed priority (index 0 wins).
// Latency: combinational grant; pointer moves on the cycle after an upd strobe.
// Backpressure: none; grant is valid whenever any request is high.
module axi_rr_arbiter #(
    parameter int N = 2
) (
`ifdef AXI_RR_ARB_EN
    input  logic         clk,
    input  logic         rst_n,
    input  logic         upd,
`endif
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

`ifdef AXI_RR_ARB_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last;

    // Search from the slot after the last winner, first requester wins
    always_comb begin
        int idx;
        gnt = '0;
        idx = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(last) + 1 + i) % N;
            if ((gnt == '0) && req[idx]) gnt[idx] = 1'b1;
        end
    end

    // Remember the last winner; reset value makes index 0 the first choice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= PW'(N - 1);
        end else if (upd) begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) last <= PW'(i);
            end
        end
    end
`else
    // Fixed priority: the lowest requesting index wins
    always_comb begin
        gnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/axi_read_xbar.sv
// AXI read crossbar, NUM_M masters to NUM_S slaves plus an internal DECERR slave, one transaction in flight; AXI_RR_ARB_EN selects round-robin arbitration.
// Latency: AR accepted in the grant cycle, forwarded next cycle until slave ARREADY; R path is combinational.
// Backpressure: ungranted masters see ARREADY=0; R ready/valid passes straight between granted master and target.
module axi_read_xbar
    import axi_xbar_pkg::*;
#(
    parameter int          NUM_M               = 2,
    parameter int          NUM_S               = 5,
    parameter int          AXI_ID_BITS         = 4,
    parameter logic [31:0] SLV_BASE [NUM_S]    = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
                                                   32'h0003_0000, 32'h0004_0000},
    parameter logic [31:0] SLV_MASK [NUM_S]    = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                                   32'hFFFF_0000, 32'hFFFF_0000}
) (
    input logic            ACLK,
    input logic            ARESETn,
    axi_read_xbar_if.slave  m_bus,   // masters drive requests into the crossbar
    axi_read_xbar_if.master s_bus    // crossbar drives requests into the slaves
);

    xbar_state_t            state, state_nxt;
    logic [NUM_M-1:0]       req, gnt;
    logic [MIDX_W-1:0]      gnt_idx_c, gnt_idx;
    logic [AXI_ID_BITS-1:0] arid_c, arid_q;
    ar_pld_t                pld_c, pld_q;
    logic [3:0]             tgt_c, tgt_q;
    logic                   ds_c, ds_q;
    logic [3:0]             ds_cnt;
    logic                   s_ar_rdy;
    logic                   g_rvalid, g_rready, g_rlast, g_fire;
    logic [31:0]            g_rdata;
    logic [1:0]             g_rresp;
    logic [AXI_ID_BITS-1:0] g_rid;

`ifdef AXI_RR_ARB_EN
    logic arb_upd;
    assign arb_upd = (state == IDLE) && (|req);
`endif

    axi_rr_arbiter #(.N(NUM_M)) u_arb (
`ifdef AXI_RR_ARB_EN
        .clk   (ACLK),
        .rst_n (ARESETn),
        .upd   (arb_upd),
`endif
        .req   (req),
        .gnt   (gnt)
    );

    // Collect master AR requests and mux out the granted master's payload
    always_comb begin
        gnt_idx_c = '0;
        arid_c    = '0;
        pld_c     = '0;
        for (int m = 0; m < NUM_M; m++) begin
            req[m] = m_bus.arvalid[m];
            if (gnt[m]) begin
                gnt_idx_c = MIDX_W'(m);
                arid_c    = m_bus.arid[m];
                pld_c     = '{addr: m_bus.araddr[m], len: m_bus.arlen[m],
                              size: m_bus.arsize[m], burst: m_bus.arburst[m]};
            end
        end
    end

    // Address decode: descending scan so the lowest matching slave wins; no match goes to DS
    always_comb begin
        ds_c  = 1'b1;
        tgt_c = '0;
        for (int s = NUM_S - 1; s >= 0; s--) begin
            if ((pld_c.addr & SLV_MASK[s]) == SLV_BASE[s]) begin
                ds_c  = 1'b0;
                tgt_c = 4'(s);
            end
        end
    end

    // R channel from the target (or the DS) toward the granted master, and its ready back
    always_comb begin
        s_ar_rdy = 1'b0;
        g_rvalid = 1'b0;
        g_rready = 1'b0;
        g_rlast  = 1'b0;
        g_rdata  = '0;
        g_rresp  = RESP_OKAY;
        g_rid    = '0;
        for (int s = 0; s < NUM_S; s++) begin
            if (tgt_q == 4'(s)) s_ar_rdy = s_bus.arready[s];
        end
        if (state == DATA) begin
            if (ds_q) begin
                g_rvalid = 1'b1;
                g_rresp  = RESP_DECERR;
                g_rlast  = (ds_cnt == pld_q.len);
                g_rid    = arid_q;
            end else begin
                for (int s = 0; s < NUM_S; s++) begin
                    if (tgt_q == 4'(s)) begin
                        g_rvalid = s_bus.rvalid[s];
                        g_rdata  = s_bus.rdata[s];
                        g_rresp  = s_bus.rresp[s];
                        g_rlast  = s_bus.rlast[s];
                        g_rid    = s_bus.rid[s][AXI_ID_BITS-1:0];
                    end
                end
            end
        end
        for (int m = 0; m < NUM_M; m++) begin
            if (gnt_idx == MIDX_W'(m)) g_rready = m_bus.rready[m];
        end
        g_fire = g_rvalid && g_rready && g_rlast;
    end

    // Next-state logic: grant -> forward AR -> stream R until the last beat
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|req) state_nxt = ADDR;
            ADDR:    if (ds_q || s_ar_rdy) state_nxt = DATA;
            DATA:    if (g_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Capture the granted request and run the DS beat counter
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            gnt_idx <= '0;
            arid_q  <= '0;
            pld_q   <= '0;
            tgt_q   <= '0;
            ds_q    <= 1'b0;
            ds_cnt  <= '0;
        end else begin
            if ((state == IDLE) && (|req)) begin
                gnt_idx <= gnt_idx_c;
                arid_q  <= arid_c;
                pld_q   <= pld_c;
                tgt_q   <= tgt_c;
                ds_q    <= ds_c;
                ds_cnt  <= '0;
            end
            if ((state == DATA) && ds_q && g_rvalid && g_rready) begin
                ds_cnt <= g_rlast ? 4'd0 : ds_cnt + 4'd1;
            end
        end
    end

    // Master-side outputs; ARREADY is forced low while reset is asserted
    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            logic sel;
            sel                = (state == DATA) && (gnt_idx == MIDX_W'(m));
            m_bus.arready[m]   = ARESETn && (state == IDLE) && gnt[m];
            m_bus.rvalid[m]    = sel && g_rvalid;
            m_bus.rlast[m]     = sel && g_rlast;
            m_bus.rdata[m]     = sel ? g_rdata : '0;
            m_bus.rresp[m]     = sel ? g_rresp : RESP_OKAY;
            m_bus.rid[m]       = sel ? g_rid   : '0;
        end
    end

    // Slave-side outputs; payload is broadcast, only the target sees ARVALID/RREADY
    always_comb begin
        for (int s = 0; s < NUM_S; s++) begin
            s_bus.arid[s]    = {gnt_idx, arid_q};
            s_bus.araddr[s]  = pld_q.addr;
            s_bus.arlen[s]   = pld_q.len;
            s_bus.arsize[s]  = pld_q.size;
            s_bus.arburst[s] = pld_q.burst;
            s_bus.arvalid[s] = (state == ADDR) && !ds_q && (tgt_q == 4'(s));
            s_bus.rready[s]  = (state == DATA) && !ds_q && (tgt_q == 4'(s)) && g_rready;
        end
    end

endmodule

// File: tb/tb_axi_read_xbar.sv
// Directed testbench for axi_read_xbar: behavioural slaves on S0..S3, a stray responder on S4.
// Latency: n/a.
// Backpressure: slave ARREADY delay and master RREADY stall patterns are programmable.
module tb_axi_read_xbar;
    import axi_xbar_pkg::*;

    logic clk = 1'b0;
    logic ARESETn = 1'b1;

    axi_read_xbar_if #(.N(2), .IDW(4)) m_if ();
    axi_read_xbar_if #(.N(5), .IDW(8)) s_if ();

    axi_read_xbar dut (
        .ACLK    (clk),
        .ARESETn (ARESETn),
        .m_bus   (m_if),
        .s_bus   (s_if)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor state
    int          ar_m_cnt [2] = '{0, 0};
    int          ar_s_cyc = 0;
    int          ar_chg = 0;
    int          stray_rdy = 0;
    int          gnt_log [$];
    logic [7:0]  last_arid = '0;
    logic [31:0] last_araddr = '0;
    logic [3:0]  last_arlen = '0;
    int          last_s = -1;

    // Slave model state
    int ar_delay [4] = '{0, 0, 0, 0};

    // Monitor: grants, slave AR activity and payload stability
    initial begin
        logic [47:0] cur_pl, prev_pl;
        bit any, hs, prev_vld;
        prev_pl = '0; prev_vld = 0;
        forever begin
            @(negedge clk);
            any = 0; hs = 0; cur_pl = '0;
            for (int m = 0; m < 2; m++) begin
                if (m_if.arready[m]) begin
                    ar_m_cnt[m]++;
                    gnt_log.push_back(m);
                end
            end
            for (int s = 0; s < 5; s++) begin
                if (s_if.arvalid[s]) begin
                    any = 1;
                    cur_pl = {s_if.arid[s], s_if.araddr[s], s_if.arlen[s], 4'(s)};
                    if (s_if.arready[s]) begin
                        hs = 1;
                        last_arid = s_if.arid[s]; last_araddr = s_if.araddr[s];
                        last_arlen = s_if.arlen[s]; last_s = s;
                    end
                end
            end
            if (any) begin
                ar_s_cyc++;
                if (prev_vld && (cur_pl != prev_pl)) ar_chg++;
                prev_pl = cur_pl;
            end
            prev_vld = any && !hs;
            if (s_if.rready[4]) stray_rdy++;
        end
    end

    // Slave model for S0..S3; S4 permanently presents a stray response
    initial begin
        bit busy, ar_fire, ar_seen, r_fire;
        int cur, nx_s, len, nx_len, beat, ar_wait;
        logic [7:0] cur_id, nx_id;
        busy = 0; cur = 0; nx_s = 0; len = 0; nx_len = 0; beat = 0; ar_wait = 0;
        cur_id = '0; nx_id = '0;
        for (int s = 0; s < 5; s++) begin
            s_if.arready[s] = 0; s_if.rvalid[s] = 0; s_if.rdata[s] = '0;
            s_if.rresp[s] = 2'b00; s_if.rlast[s] = 0; s_if.rid[s] = '0;
        end
        s_if.rvalid[4] = 1; s_if.rdata[4] = 32'hDEAD_BEEF; s_if.rlast[4] = 1; s_if.rid[4] = 8'hFF;
        forever begin
            @(negedge clk);
            ar_fire = 0; ar_seen = 0; r_fire = 0;
            for (int s = 0; s < 4; s++) begin
                if (s_if.arvalid[s]) ar_seen = 1;
                if (s_if.arvalid[s] && s_if.arready[s]) begin
                    ar_fire = 1; nx_s = s; nx_id = s_if.arid[s]; nx_len = int'(s_if.arlen[s]);
                end
            end
            if (busy && s_if.rvalid[cur] && s_if.rready[cur]) r_fire = 1;
            @(posedge clk); #1;
            if (!ARESETn) begin
                busy = 0; ar_wait = 0;
            end else begin
                if (r_fire) begin
                    beat++;
                    if (beat > len) busy = 0;
                end
                if (ar_fire) begin
                    busy = 1; cur = nx_s; cur_id = nx_id; len = nx_len; beat = 0; ar_wait = 0;
                end else if (ar_seen) begin
                    ar_wait++;
                end
            end
            for (int s = 0; s < 4; s++) begin
                s_if.arready[s] = s_if.arvalid[s] && !busy && (ar_wait >= ar_delay[s]);
                s_if.rvalid[s]  = busy && (s == cur);
                s_if.rdata[s]   = 32'hA000_0000 | (32'(s) << 16) | 32'(beat);
                s_if.rresp[s]   = 2'b00;
                s_if.rlast[s]   = busy && (s == cur) && (beat == len);
                s_if.rid[s]     = cur_id;
            end
        end
    end

    // One read from master m; exp_s < 0 means the default (DECERR) slave
    task automatic read_txn(input int m, input logic [3:0] id, input logic [31:0] addr,
                            input int len, input int exp_s, input logic [7:0] stall);
        int cyc, beat;
        logic [31:0] ed, held;
        bit was_stalled;
        @(posedge clk); #1;
        m_if.arid[m] = id; m_if.araddr[m] = addr; m_if.arlen[m] = 4'(len);
        m_if.arsize[m] = 3'd2; m_if.arburst[m] = 2'd1; m_if.arvalid[m] = 1;
        cyc = 0;
        @(negedge clk);
        while (!m_if.arready[m] && cyc < 50) begin @(negedge clk); cyc++; end
        check_eq("ar_accept", m_if.arready[m], 1'b1);
        @(posedge clk); #1;
        m_if.arvalid[m] = 0;
        beat = 0; cyc = 0; was_stalled = 0; held = '0;
        while (beat <= len && cyc < 100) begin
            m_if.rready[m] = !stall[cyc % 8];
            @(negedge clk);
            check_eq("r_other_quiet", m_if.rvalid[1-m], 1'b0);
            if (was_stalled) begin
                check_eq("stall_vld", m_if.rvalid[m], 1'b1);
                check_eq("stall_dat", m_if.rdata[m], held);
            end
            was_stalled = m_if.rvalid[m] && !m_if.rready[m];
            held = m_if.rdata[m];
            if (m_if.rvalid[m] && m_if.rready[m]) begin
                ed = (exp_s < 0) ? 32'h0 : (32'hA000_0000 | (32'(exp_s) << 16) | 32'(beat));
                check_eq("r_data", m_if.rdata[m], ed);
                check_eq("r_resp", m_if.rresp[m], (exp_s < 0) ? 2'b11 : 2'b00);
                check_eq("r_id", m_if.rid[m], id);
                check_eq("r_last", m_if.rlast[m], beat == len);
                beat++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        m_if.rready[m] = 0;
        check_eq("r_beats", beat, len + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int cyc, nb, c0, g0, g1, x0;

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_if.arid[m] = '0; m_if.araddr[m] = '0; m_if.arlen[m] = '0;
            m_if.arsize[m] = '0; m_if.arburst[m] = '0; m_if.arvalid[m] = 0; m_if.rready[m] = 0;
        end
        m_if.arvalid[0] = 1;
        #1 ARESETn = 0;

        // Reset state, with a pending request and a stray slave response present
        @(negedge clk);
        check_eq("rst_state", dut.state, IDLE);
        check_eq("rst_arready_m0", m_if.arready[0], 1'b0);
        check_eq("rst_rvalid_m0", m_if.rvalid[0], 1'b0);
        check_eq("rst_rvalid_m1", m_if.rvalid[1], 1'b0);
        check_eq("rst_arvalid_s", ar_s_cyc, 0);
        check_eq("rst_rready_s4", s_if.rready[4], 1'b0);
        m_if.arvalid[0] = 0;
        #2 ARESETn = 1;

        // Arbitration with both masters requesting back to back
        gnt_log.delete();
        g1 = ar_m_cnt[1];
        @(posedge clk); #1;
        m_if.arid[0] = 4'h1; m_if.araddr[0] = 32'h0000_0100; m_if.arlen[0] = 4'd0; m_if.arvalid[0] = 1;
        m_if.arid[1] = 4'h2; m_if.araddr[1] = 32'h0003_0000; m_if.arlen[1] = 4'd0; m_if.arvalid[1] = 1;
        m_if.rready[0] = 1; m_if.rready[1] = 1;
        cyc = 0;
        while (gnt_log.size() < 3 && cyc < 100) begin @(negedge clk); #1; cyc++; end
        @(posedge clk); #1;
        m_if.arvalid[0] = 0; m_if.arvalid[1] = 0;
        check_eq("arb_ngrants", gnt_log.size() >= 3, 1'b1);
        if (gnt_log.size() >= 3) begin
            check_eq("arb_g0", gnt_log[0], 0);
`ifdef AXI_RR_ARB_EN
            check_eq("arb_g1", gnt_log[1], 1);
            check_eq("arb_m1_grants", ar_m_cnt[1] - g1, 1);
`else
            check_eq("arb_g1", gnt_log[1], 0);
            check_eq("arb_m1_grants", ar_m_cnt[1] - g1, 0);
`endif
            check_eq("arb_g2", gnt_log[2], 0);
        end
        cyc = 0;
        while (dut.state != IDLE && cyc < 50) begin @(negedge clk); cyc++; end
        check_eq("arb_idle", dut.state, IDLE);
        m_if.rready[0] = 0; m_if.rready[1] = 0;

        // M0 four-beat read from S1
        read_txn(0, 4'h5, 32'h0001_0000, 3, 1, 8'h00);
        check_eq("s1_target", last_s, 1);
        check_eq("s1_arid", last_arid, 8'h05);
        check_eq("s1_araddr", last_araddr, 32'h0001_0000);
        check_eq("s1_arlen", last_arlen, 4'd3);
        check_eq("s1_idle_after", dut.state, IDLE);

        // M1 unmapped read answered by the default slave
        c0 = ar_s_cyc;
        read_txn(1, 4'hA, 32'hFFFF_0000, 1, -1, 8'h00);
        check_eq("ds_no_arvalid", ar_s_cyc - c0, 0);

        // S2 holds off ARREADY for five cycles
        ar_delay[2] = 5;
        c0 = ar_s_cyc; g0 = ar_m_cnt[0]; x0 = ar_chg;
        read_txn(0, 4'h7, 32'h0002_0010, 0, 2, 8'h00);
        check_eq("s2_arvalid_cycles", ar_s_cyc - c0, 6);
        check_eq("s2_payload_stable", ar_chg - x0, 0);
        check_eq("s2_m_arready_once", ar_m_cnt[0] - g0, 1);
        check_eq("s2_arid", last_arid, 8'h07);
        ar_delay[2] = 0;

        // RREADY stalls during the data phase from S0
        read_txn(1, 4'h3, 32'h0000_0200, 3, 0, 8'b0000_1010);
        check_eq("stall_arid", last_arid, 8'h13);

        // Reset in beat 2 of a 4-beat read
        @(posedge clk); #1;
        m_if.arid[0] = 4'h3; m_if.araddr[0] = 32'h0001_0040; m_if.arlen[0] = 4'd3; m_if.arvalid[0] = 1;
        cyc = 0;
        @(negedge clk);
        while (!m_if.arready[0] && cyc < 50) begin @(negedge clk); cyc++; end
        check_eq("mr_accept", m_if.arready[0], 1'b1);
        @(posedge clk); #1;
        m_if.arvalid[0] = 0; m_if.rready[0] = 1;
        nb = 0; cyc = 0;
        while (nb < 1 && cyc < 50) begin
            @(negedge clk);
            if (m_if.rvalid[0] && m_if.rready[0]) nb++;
            cyc++;
        end
        @(posedge clk); #2;
        check_eq("mr_beat2_valid", m_if.rvalid[0], 1'b1);
        ARESETn = 0;
        #1;
        check_eq("mr_rvalid_m0", m_if.rvalid[0], 1'b0);
        check_eq("mr_rlast_m0", m_if.rlast[0], 1'b0);
        check_eq("mr_rdata_m0", m_if.rdata[0], 32'h0);
        check_eq("mr_rready_s1", s_if.rready[1], 1'b0);
        check_eq("mr_arvalid_s1", s_if.arvalid[1], 1'b0);
        check_eq("mr_state", dut.state, IDLE);
        m_if.rready[0] = 0;
        repeat (2) @(negedge clk);
        ARESETn = 1;
        read_txn(0, 4'h6, 32'h0001_0080, 2, 1, 8'h00);
        check_eq("mr_post_arid", last_arid, 8'h06);
        check_eq("mr_post_idle", dut.state, IDLE);

        check_eq("stray_rready_s4", stray_rdy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
